mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/lsu_pkg.sv | 52 +++++
 rtl/mem_stage_lsu_load_align.sv | 37 +++
 rtl/mem_stage_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the MEM-stage load/store unit:
//                FSM state encoding, funct3 load-type codes, the default
//                bus timeout, and the alignment-check helper used when the
//                misalignment trap (LSU_MISALIGN_TRAP_EN) is built in.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Default number of wait cycles tolerated before a bus access is aborted.
    localparam int TIMEOUT_CYCLES_DEF = 255;

    // Width of the BUSY wait counter.
    localparam int WAIT_CNT_W = 8;

    // FSM state encoding.
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_BUSY = 2'd1;
    localparam lsu_state_t ST_DONE = 2'd2;

    // funct3 load-type codes. Anything else is handled as a word load.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Alignment check. Stores derive their size from the byte mask,
    // loads from funct3; byte accesses can never be misaligned.
    function automatic logic lsu_misaligned(
        input logic       is_store,
        input logic [3:0] mask,
        input logic [2:0] funct3,
        input logic [1:0] offset
    );
        logic is_half;
        logic is_word;
        if (is_store) begin
            is_half = (mask == 4'b0011);
            is_word = (mask == 4'b1111);
        end else begin
            is_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
            is_word = !(is_half || (funct3 == F3_LB) || (funct3 == F3_LBU));
        end
        return (is_half && offset[0]) || (is_word && (offset != 2'b00));
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/mem_stage_lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_align
//  Description : Purely combinational load-result formatter. Shifts the bus
//                read word down by the byte offset, then sign- or
//                zero-extends according to funct3. Unsupported funct3 codes
//                return the full shifted word (LW behaviour).
//  Ports       : drdata  [31:0] in  - raw word from the data bus
//                offset  [1:0]  in  - byte offset of the access
//                funct3  [2:0]  in  - load type
//                rdata   [31:0] out - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] drdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = drdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   rdata = {{24{w_shifted[7]}},  w_shifted[7:0]};
            F3_LH:   rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  rdata = {24'd0, w_shifted[7:0]};
            F3_LHU:  rdata = {16'd0, w_shifted[15:0]};
            default: rdata = w_shifted;
        endcase
    end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : MEM-stage load/store unit. Converts an EX/MEM access into a
//                single data-bus transaction (IDLE -> BUSY -> DONE), stalls
//                the pipeline while it is outstanding, formats load data and
//                aborts with bus_err if dack does not arrive in time.
//  Build option: LSU_MISALIGN_TRAP_EN - when defined, misaligned halfword and
//                word accesses skip the bus and pulse misalign_err instead.
//  Ports       : clk, rst_n                      clock / async active-low reset
//                memtoreg_in, memwrite_in[3:0]   access request (load / store mask)
//                addr_in[31:0], wdata_in[31:0]   effective address / store data
//                funct3_in[2:0]                  load size and sign
//                stall_out                       holds the EX/MEM register
//                rdata_out[31:0], rdata_valid    load result and update pulse
//                dreq, daddr, dwdata, dwe        data-bus request side
//                dack, drdata                    data-bus response side
//                bus_err, misalign_err           one-cycle error pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memtoreg_in,
    input  logic [3:0]  memwrite_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [2:0]  funct3_in,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        dreq,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic        dack,
    input  logic [31:0] drdata,
    output logic        bus_err,
    output logic        misalign_err
);

    // Timeout compare value, clamped to what the 8-bit counter can reach.
    localparam logic [WAIT_CNT_W-1:0] C_TIMEOUT_CNT =
        (TIMEOUT_CYCLES > 255) ? 8'd255 : 8'(TIMEOUT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] C_WAIT_MAX = 8'hFF;

    lsu_state_t state_q, state_d;

    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]           daddr_q,    daddr_d;
    logic [31:0]           dwdata_q,   dwdata_d;
    logic [3:0]            dwe_q,      dwe_d;
    logic                  is_load_q,  is_load_d;
    logic [1:0]            offset_q,   offset_d;
    logic [2:0]            funct3_q,   funct3_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  rdata_valid_q,  rdata_valid_d;
    logic                  bus_err_q,      bus_err_d;
    logic                  misalign_err_q, misalign_err_d;

    logic        w_access;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_timeout;
    logic [31:0] w_load_word;

    // A request carrying both a load flag and a store mask is a store.
    assign w_is_store = (memwrite_in != 4'b0000);
    assign w_access   = memtoreg_in || w_is_store;
    assign w_timeout  = (wait_cnt_q == C_TIMEOUT_CNT);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_access &&
                        lsu_misaligned(w_is_store, memwrite_in, funct3_in, addr_in[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    lsu_load_align u_load_align (
        .drdata (drdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .rdata  (w_load_word)
    );

    // ---------------------------------------------------------------- FSM --
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_access) begin
                    state_d = w_misalign ? ST_DONE : ST_BUSY;
                end
            end
            // dack takes priority over a timeout landing in the same cycle.
            ST_BUSY: begin
                if (dack || w_timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall is combinational in IDLE so the very first access cycle holds
    // the pipeline; it is forced low while reset is asserted.
    always_comb begin
        stall_out = rst_n && (((state_q == ST_IDLE) && w_access) || (state_q == ST_BUSY));
        dreq      = (state_q == ST_BUSY);
    end

    // ----------------------------------------------------------- datapath --
    always_comb begin
        wait_cnt_d     = wait_cnt_q;
        daddr_d        = daddr_q;
        dwdata_d       = dwdata_q;
        dwe_d          = dwe_q;
        is_load_d      = is_load_q;
        offset_d       = offset_q;
        funct3_d       = funct3_q;
        rdata_d        = rdata_q;
        rdata_valid_d  = 1'b0;
        bus_err_d      = 1'b0;
        misalign_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_access) begin
                    wait_cnt_d     = '0;
                    daddr_d        = {addr_in[31:2], 2'b00};
                    dwdata_d       = wdata_in << {addr_in[1:0], 3'b000};
                    dwe_d          = w_is_store ? (memwrite_in << addr_in[1:0]) : 4'b0000;
                    is_load_d      = !w_is_store;
                    offset_d       = addr_in[1:0];
                    funct3_d       = funct3_in;
                    misalign_err_d = w_misalign;
                end
            end
            ST_BUSY: begin
                if (dack) begin
                    if (is_load_q) begin
                        rdata_d       = w_load_word;
                        rdata_valid_d = 1'b1;
                    end
                end else if (w_timeout) begin
                    bus_err_d = 1'b1;
                end else if (wait_cnt_q != C_WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q     <= '0;
            daddr_q        <= '0;
            dwdata_q       <= '0;
            dwe_q          <= '0;
            is_load_q      <= 1'b0;
            offset_q       <= '0;
            funct3_q       <= '0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
        end else begin
            wait_cnt_q     <= wait_cnt_d;
            daddr_q        <= daddr_d;
            dwdata_q       <= dwdata_d;
            dwe_q          <= dwe_d;
            is_load_q      <= is_load_d;
            offset_q       <= offset_d;
            funct3_q       <= funct3_d;
            rdata_q        <= rdata_d;
            rdata_valid_q  <= rdata_valid_d;
            bus_err_q      <= bus_err_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    assign daddr        = daddr_q;
    assign dwdata       = dwdata_q;
    assign dwe          = dwe_q;
    assign rdata_out    = rdata_q;
    assign rdata_valid  = rdata_valid_q;
    assign bus_err      = bus_err_q;
    assign misalign_err = misalign_err_q;

endmodule : mem_stage_lsu
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Self-checking bench for mem_stage_lsu with a transaction-
//                level reference model (TIMEOUT_CYCLES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memtoreg_in = 1'b0;
    logic [3:0]  memwrite_in = 4'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        dreq;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic        dack = 1'b0;
    logic [31:0] drdata = '0;
    logic        bus_err;
    logic        misalign_err;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memtoreg_in  (memtoreg_in),
        .memwrite_in  (memwrite_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .funct3_in    (funct3_in),
        .stall_out    (stall_out),
        .rdata_out    (rdata_out),
        .rdata_valid  (rdata_valid),
        .dreq         (dreq),
        .daddr        (daddr),
        .dwdata       (dwdata),
        .dwe          (dwe),
        .dack         (dack),
        .drdata       (drdata),
        .bus_err      (bus_err),
        .misalign_err (misalign_err)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Expected per-cycle outputs, set by the stimulus process.
    bit          cmp_en = 1'b0;
    bit          e_stall, e_dreq, e_valid, e_berr, e_merr;
    logic [31:0] e_rdata = '0;
    logic [31:0] e_daddr = '0;
    logic [31:0] e_dwdata = '0;
    logic [3:0]  e_dwe = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ------------------------------------------------------ reference model
    function automatic logic [3:0] model_dwe(input logic [3:0] m, input logic [1:0] off);
        int v;
        v = (int'(m) << off) & 15;
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_dwdata(input logic [31:0] wd, input logic [1:0] off);
        logic [63:0] t;
        t = {32'd0, wd} << (8 * int'(off));
        return t[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [31:0] v;
        int          r;
        v = word >> (8 * int'(off));
        case (f3)
            3'b000: begin
                r = int'(v & 32'hFF);
                if (r >= 128) r -= 256;
                return 32'(r);
            end
            3'b001: begin
                r = int'(v & 32'hFFFF);
                if (r >= 32768) r -= 65536;
                return 32'(r);
            end
            3'b100:  return v & 32'hFF;
            3'b101:  return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    function automatic bit model_misaligned(input bit st, input logic [3:0] m,
                                            input logic [2:0] f3, input logic [1:0] off);
        int size;
        if (st) size = (m == 4'b1111) ? 4 : ((m == 4'b0011) ? 2 : 1);
        else    size = (f3 == 3'b000 || f3 == 3'b100) ? 1 :
                       ((f3 == 3'b001 || f3 == 3'b101) ? 2 : 4);
        return (int'(off) % size) != 0;
    endfunction

    task automatic set_exp(input bit s, input bit r, input bit v, input bit b, input bit m);
        e_stall = s; e_dreq = r; e_valid = v; e_berr = b; e_merr = m;
    endtask

    // ------------------------------------------------------ compare process
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall_out",    32'(stall_out),    32'(e_stall));
            check("dreq",         32'(dreq),         32'(e_dreq));
            check("rdata_valid",  32'(rdata_valid),  32'(e_valid));
            check("bus_err",      32'(bus_err),      32'(e_berr));
            check("misalign_err", 32'(misalign_err), 32'(e_merr));
            check("rdata_out",    rdata_out,         e_rdata);
            if (e_dreq) begin
                check("daddr",  daddr,       e_daddr);
                check("dwe",    32'(dwe),    32'(e_dwe));
                check("dwdata", dwdata,      e_dwdata);
            end
        end
    end

    // One access: IDLE cycle, BUSY cycles (dack on BUSY cycle index d, or
    // timeout after TO wait cycles), DONE cycle. Returns at the next IDLE.
    task automatic run_txn(input bit ld, input logic [3:0] m, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3,
                           input int d, input logic [31:0] word);
        bit st;
        bit mis;
        bit acked;
        st    = (m != 4'b0000);
        mis   = 1'b0;
        acked = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = model_misaligned(st, m, f3, a[1:0]);
`endif
        memtoreg_in = ld; memwrite_in = m; addr_in = a; wdata_in = wd; funct3_in = f3;
        dack = 1'b0; drdata = $urandom;
        e_daddr  = {a[31:2], 2'b00};
        e_dwe    = st ? model_dwe(m, a[1:0]) : 4'b0000;
        e_dwdata = model_dwdata(wd, a[1:0]);
        set_exp(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        if (!mis) begin
            for (int k = 0; k <= TO; k++) begin
                acked  = (k == d);
                dack   = acked;
                drdata = acked ? word : $urandom;
                // EX/MEM contents are not trusted while the bus is busy.
                memtoreg_in = 1'($urandom); memwrite_in = 4'($urandom);
                addr_in = $urandom; wdata_in = $urandom; funct3_in = 3'($urandom);
                set_exp(1, 1, 0, 0, 0);
                @(posedge clk); #1;
                if (acked) break;
            end
        end
        dack = 1'($urandom); drdata = $urandom;
        if (acked && !st) e_rdata = model_load(word, a[1:0], f3);
        set_exp(0, 0, acked && !st, !acked && !mis, mis);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            memtoreg_in = 1'b0; memwrite_in = 4'b0000;
            addr_in = $urandom; dack = 1'($urandom); drdata = $urandom;
            set_exp(0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        set_exp(0, 0, 0, 0, 0);

        // Model pins against hand-computed values.
        check("pin_sb_dwe",    32'(model_dwe(4'b0001, 2'd3)), 32'h8);
        check("pin_sb_dwdata", model_dwdata(32'h000000AB, 2'd3), 32'hAB000000);
        check("pin_lb",        model_load(32'h0080FF00, 2'd2, 3'b000), 32'hFFFFFF80);
        check("pin_lbu",       model_load(32'h0080FF00, 2'd2, 3'b100), 32'h00000080);

        // Reset state with a pending request on the inputs.
        memtoreg_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_out), 0);
        check("rst_dreq",  32'(dreq), 0);
        check("rst_dwe",   32'(dwe), 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_daddr", daddr, 0);
        check("rst_errs",  32'({bus_err, misalign_err, rdata_valid}), 0);
        memtoreg_in = 1'b0;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        idle_cycles(2);

        // Directed cases.
        run_txn(0, 4'b1111, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0);
        run_txn(0, 4'b0001, 32'h103, 32'h000000AB, 3'b000, 1, 32'h0);
        run_txn(1, 4'b0000, 32'h202, 32'h0, 3'b000, 0, 32'h0080FF00);
        check("lit_lb", rdata_out, 32'hFFFFFF80);
        run_txn(1, 4'b0000, 32'h202, 32'h0, 3'b100, 2, 32'h0080FF00);
        check("lit_lbu", rdata_out, 32'h00000080);
        run_txn(1, 4'b0000, 32'h204, 32'h0, 3'b010, 1000, 32'h11111111);
        check("lit_timeout_rdata", rdata_out, 32'h00000080);
        run_txn(1, 4'b0000, 32'h102, 32'h0, 3'b010, 0, 32'h12345678);
`ifndef LSU_MISALIGN_TRAP_EN
        check("lit_lw_misaligned", rdata_out, 32'h00001234);
`endif
        idle_cycles(1);

        // Reset while BUSY, then a stray dack after release.
        memtoreg_in = 1'b1; memwrite_in = 4'b0; addr_in = 32'h300; wdata_in = 32'h0;
        funct3_in = 3'b010; dack = 1'b0;
        set_exp(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        e_daddr = 32'h300; e_dwe = 4'b0; e_dwdata = 32'h0;
        set_exp(1, 1, 0, 0, 0);
        #1 check("busy_dreq", 32'(dreq), 1);
        #1 rst_n = 1'b0; cmp_en = 1'b0;
        #1 check("rst_busy_dreq",  32'(dreq), 0);
        check("rst_busy_stall", 32'(stall_out), 0);
        check("rst_busy_rdata", rdata_out, 0);
        e_rdata = '0;
        @(posedge clk); #1;
        rst_n = 1'b1; memtoreg_in = 1'b0;
        dack = 1'b1; drdata = 32'hFFFFFFFF;
        set_exp(0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        dack = 1'b0;

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [3:0] m;
            kind = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       m = 4'b0001;
                1:       m = 4'b0011;
                default: m = 4'b1111;
            endcase
            run_txn(kind != 2, (kind >= 2) ? m : 4'b0000, $urandom, $urandom,
                    3'($urandom), $urandom_range(0, TO + 2), $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d passed %0d", chk_cnt, pass_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_stage_lsu
`default_nettype wire
